unified_mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/arb_tag_pipe.sv | 27 ++
 rtl/unified_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   localparam logic [2:0] FUN3_WORD  = 3'b010;
   localparam int         RD_LAT_MIN = 1;
   localparam int         RD_LAT_MAX = 4;

   function automatic logic rd_lat_ok(input int lat);
      return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
   endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Owner-tag delay line matching the memory read latency; cleared synchronously so
// nothing issued before a reset can surface afterwards.
module arb_tag_pipe
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic   clk,
   input  logic   clr,
   input  owner_t tag_in,
   output owner_t tag_out
);

   owner_t stage [DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= OWN_NONE;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/unified_mem_arbiter.sv
// Per-cycle arbiter sharing the single-ported unified memory between fetch and load/store.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module unified_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_stall,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_fun3,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [2:0]        mem_fun3,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
      $error("unified_mem_arbiter: RD_LAT out of range 1..4");
   end
   if (STARVE_MAX < 1) begin : g_bad_starve_max
      $error("unified_mem_arbiter: STARVE_MAX must be at least 1");
   end

   logic              force_if;
   owner_t            tag_in;
   owner_t            tag_out;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt;

   // Counts consecutive denied fetch cycles; saturates so the force stays asserted.
   always_ff @(posedge clk) begin
      if (rst || !if_req || if_gnt) begin
         starve_cnt <= '0;
      end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   assign force_if = (starve_cnt == CNT_W'(STARVE_MAX));
`else
   assign force_if = 1'b0;
`endif

   always_comb begin
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      mem_addr  = if_addr;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_fun3  = '0;
      mem_wdata = '0;
      tag_in    = OWN_NONE;
      if (rst) begin
         mem_addr = '0;
      end else if (d_req && !(force_if && if_req)) begin
         d_gnt     = 1'b1;
         mem_addr  = d_addr;
         mem_re    = !d_we;
         mem_we    = d_we;
         mem_fun3  = d_fun3;
         mem_wdata = d_wdata;
         tag_in    = d_we ? OWN_NONE : OWN_D;
      end else if (if_req) begin
         if_gnt    = 1'b1;
         mem_re    = 1'b1;
         mem_fun3  = FUN3_WORD;
         tag_in    = OWN_IF;
      end
   end

   assign if_stall = if_req && !if_gnt && !rst;

   arb_tag_pipe #(
      .DEPTH (RD_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .clr     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // Gate with rst so a tag still in flight during the reset cycle never shows up.
   assign if_rvalid = !rst && (tag_out == OWN_IF);
   assign d_rvalid  = !rst && (tag_out == OWN_D);

   always_ff @(posedge clk) begin
      if (rst) begin
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         if (if_rvalid) if_rdata_q <= mem_rdata;
         if (d_rvalid)  d_rdata_q  <= mem_rdata;
      end
   end

   assign if_rdata = rst ? '0 : (if_rvalid ? mem_rdata : if_rdata_q);
   assign d_rdata  = rst ? '0 : (d_rvalid  ? mem_rdata : d_rdata_q);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance at RD_LAT=1, one at RD_LAT=3,
// each backed by its own behavioural memory.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [5:0]  if_addr, d_addr;
   logic [2:0]  d_fun3;
   logic [31:0] d_wdata;

   logic        if_gnt_1, if_stall_1, if_rvalid_1, d_gnt_1, d_rvalid_1, mem_re_1, mem_we_1;
   logic [31:0] if_rdata_1, d_rdata_1, mem_wdata_1, mem_rdata_1;
   logic [5:0]  mem_addr_1;
   logic [2:0]  mem_fun3_1;

   logic        if_gnt_3, if_stall_3, if_rvalid_3, d_gnt_3, d_rvalid_3, mem_re_3, mem_we_3;
   logic [31:0] if_rdata_3, d_rdata_3, mem_wdata_3, mem_rdata_3;
   logic [5:0]  mem_addr_3;
   logic [2:0]  mem_fun3_3;

   logic [31:0] mem1 [64];
   logic [31:0] mem3 [64];
   logic [31:0] rp1;
   logic [31:0] rp3 [3];

   int n_vec = 0;
   int n_err = 0;
   logic guard_en;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.ADDR_W(6), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) u_dut1 (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1),
      .if_stall(if_stall_1), .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1),
      .d_req(d_req), .d_we(d_we), .d_fun3(d_fun3), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_1), .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1),
      .mem_addr(mem_addr_1), .mem_re(mem_re_1), .mem_we(mem_we_1), .mem_fun3(mem_fun3_1),
      .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1));

   unified_mem_arbiter #(.ADDR_W(6), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3),
      .if_stall(if_stall_3), .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3),
      .d_req(d_req), .d_we(d_we), .d_fun3(d_fun3), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_3), .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3),
      .mem_addr(mem_addr_3), .mem_re(mem_re_3), .mem_we(mem_we_3), .mem_fun3(mem_fun3_3),
      .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3));

   // Behavioural memories: read data appears RD_LAT cycles after the address.
   always @(posedge clk) begin
      rp1 <= mem1[mem_addr_1];
      if (mem_we_1) mem1[mem_addr_1] <= mem_wdata_1;
      rp3[0] <= mem3[mem_addr_3];
      rp3[1] <= rp3[0];
      rp3[2] <= rp3[1];
      if (mem_we_3) mem3[mem_addr_3] <= mem_wdata_3;
   end
   assign mem_rdata_1 = rp1;
   assign mem_rdata_3 = rp3[2];

   function automatic logic [31:0] pat(input int a);
      return 32'h1000_0000 + 32'(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      if_req  = 1'b0;
      if_addr = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_fun3  = '0;
      d_addr  = '0;
      d_wdata = '0;
   endtask

   task automatic nx();
      @(posedge clk);
      #1;
   endtask

   initial begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      guard_en = 1'b1;
`else
      guard_en = 1'b0;
`endif
      for (int i = 0; i < 64; i++) begin
         mem1[i] = pat(i);
         mem3[i] = pat(i);
      end
      rst = 1'b1;
      idle();
      nx(); nx();

      // ---- reset gating and reset mid-read ----
      if_req = 1'b1; if_addr = 6'h05;
      @(negedge clk);
      chk("rst_if_gnt", 32'(if_gnt_1), 32'd0);
      chk("rst_if_stall", 32'(if_stall_1), 32'd0);
      chk("rst_mem_re", 32'(mem_re_1), 32'd0);
      nx();
      rst = 1'b0;
      @(negedge clk);
      chk("pre_if_gnt", 32'(if_gnt_1), 32'd1);
      chk("pre_mem_addr", 32'(mem_addr_1), 32'h05);
      chk("pre_mem_re", 32'(mem_re_1), 32'd1);
      nx();
      rst = 1'b1; idle();
      @(negedge clk);
      chk("rstmid_if_rvalid1", 32'(if_rvalid_1), 32'd0);
      chk("rstmid_if_rvalid3", 32'(if_rvalid_3), 32'd0);
      nx();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_outs1", 32'(|{if_gnt_1, if_stall_1, if_rvalid_1, if_rdata_1, d_gnt_1,
             d_rvalid_1, d_rdata_1, mem_addr_1, mem_re_1, mem_we_1, mem_fun3_1, mem_wdata_1}), 32'd0);
         chk("post_rst_rvalid3", 32'({if_rvalid_3, d_rvalid_3}), 32'd0);
         nx();
      end

      // ---- fetch-only stream, RD_LAT=1 ----
      for (int k = 0; k < 5; k++) begin
         if (k < 3) begin if_req = 1'b1; if_addr = 6'(k); end
         else idle();
         @(negedge clk);
         if (k < 3) chk("fs_if_gnt", 32'(if_gnt_1), 32'd1);
         chk("fs_if_rvalid", 32'(if_rvalid_1), (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
         if (k >= 1) chk("fs_if_rdata", if_rdata_1, pat((k <= 3) ? k - 1 : 2));
         nx();
      end

      // ---- conflict: data wins, fetch issues next cycle ----
      if_req = 1'b1; if_addr = 6'h03;
      d_req = 1'b1; d_we = 1'b0; d_addr = 6'h20; d_fun3 = 3'b100;
      @(negedge clk);
      chk("cf_d_gnt", 32'(d_gnt_1), 32'd1);
      chk("cf_if_gnt", 32'(if_gnt_1), 32'd0);
      chk("cf_if_stall", 32'(if_stall_1), 32'd1);
      chk("cf_mem_addr", 32'(mem_addr_1), 32'h20);
      chk("cf_mem_fun3", 32'(mem_fun3_1), 32'd4);
      nx();
      d_req = 1'b0;
      @(negedge clk);
      chk("cf_d_rvalid", 32'(d_rvalid_1), 32'd1);
      chk("cf_d_rdata", d_rdata_1, pat(32));
      chk("cf_if_rvalid", 32'(if_rvalid_1), 32'd0);
      chk("cf_if_gnt2", 32'(if_gnt_1), 32'd1);
      chk("cf_if_stall2", 32'(if_stall_1), 32'd0);
      chk("cf_mem_addr2", 32'(mem_addr_1), 32'h03);
      chk("cf_mem_fun3_2", 32'(mem_fun3_1), 32'd2);
      nx();
      idle();
      @(negedge clk);
      chk("cf_if_rvalid2", 32'(if_rvalid_1), 32'd1);
      chk("cf_if_rdata", if_rdata_1, pat(3));
      chk("cf_d_rvalid2", 32'(d_rvalid_1), 32'd0);
      chk("cf_d_rdata_hold", d_rdata_1, pat(32));
      nx();

      // ---- store then fetch of the same word ----
      d_req = 1'b1; d_we = 1'b1; d_addr = 6'h10; d_wdata = 32'hDEADBEEF; d_fun3 = 3'b010;
      @(negedge clk);
      chk("st_d_gnt", 32'(d_gnt_1), 32'd1);
      chk("st_mem_we", 32'(mem_we_1), 32'd1);
      chk("st_mem_re", 32'(mem_re_1), 32'd0);
      chk("st_mem_wdata", mem_wdata_1, 32'hDEADBEEF);
      nx();
      idle();
      if_req = 1'b1; if_addr = 6'h10;
      @(negedge clk);
      chk("st_mem_we2", 32'(mem_we_1), 32'd0);
      chk("st_d_rvalid", 32'(d_rvalid_1), 32'd0);
      nx();
      idle();
      @(negedge clk);
      chk("st_d_rvalid2", 32'(d_rvalid_1), 32'd0);
      chk("st_if_rvalid", 32'(if_rvalid_1), 32'd1);
      chk("st_if_rdata", if_rdata_1, 32'hDEADBEEF);
      nx();

      // ---- sustained conflict: starvation guard behaviour ----
      for (int k = 0; k < 6; k++) begin
         if_req = 1'b1; if_addr = 6'h07;
         d_req = 1'b1; d_we = 1'b0; d_addr = 6'h21; d_fun3 = 3'b010;
         @(negedge clk);
         chk("gd_d_gnt1", 32'(d_gnt_1), (guard_en && k == 4) ? 32'd0 : 32'd1);
         chk("gd_if_gnt1", 32'(if_gnt_1), (guard_en && k == 4) ? 32'd1 : 32'd0);
         chk("gd_d_gnt3", 32'(d_gnt_3), (guard_en && k == 4) ? 32'd0 : 32'd1);
         nx();
      end
      idle();
      for (int k = 0; k < 4; k++) nx();

      // ---- RD_LAT=3: IF, D, IF interleave ----
      for (int k = 0; k < 7; k++) begin
         idle();
         if (k == 0) begin if_req = 1'b1; if_addr = 6'h01; end
         if (k == 1) begin d_req = 1'b1; d_we = 1'b0; d_addr = 6'h22; end
         if (k == 2) begin if_req = 1'b1; if_addr = 6'h02; end
         @(negedge clk);
         chk("lt_if_rvalid", 32'(if_rvalid_3), (k == 3 || k == 5) ? 32'd1 : 32'd0);
         chk("lt_d_rvalid", 32'(d_rvalid_3), (k == 4) ? 32'd1 : 32'd0);
         if (k == 3) chk("lt_if_rdata_a", if_rdata_3, pat(1));
         if (k == 4) chk("lt_d_rdata", d_rdata_3, pat(34));
         if (k >= 5) chk("lt_if_rdata_b", if_rdata_3, pat(2));
         nx();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
